// File: rtl/hist_pkg.sv
// ==========================================================================
// hist_pkg : shared widths, bin limit and HCU state encoding
// Rev 1.0
// ==========================================================================
`default_nettype none

package hist_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] BIN_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_RD    = 3'd3,
    S_CAP   = 3'd4,
    S_WR    = 3'd5,
    S_FIN   = 3'd6
  } hcu_state_t;

endpackage

`default_nettype wire

// File: rtl/hist_sat_inc.sv
// ==========================================================================
// hist_sat_inc : combinational saturating bin incrementer
// Rev 1.0
// ==========================================================================
`default_nettype none

module hist_sat_inc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] inc_val,
  output logic              sat
);

  localparam logic [DATA_W-1:0] MAX_VAL = '1;

  assign sat     = (val == MAX_VAL);
  assign inc_val = sat ? val : val + 1'b1;

endmodule

`default_nettype wire

// File: rtl/hist_train_hcu.sv
// ==========================================================================
// hist_train_hcu : training histogram compute unit (clear + RMW bin counting)
// Rev 1.0
// ==========================================================================
`default_nettype none

module hist_train_hcu
  import hist_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_BINS = 2097152,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_en,
  input  logic              bin_valid,
  input  logic [ADDR_W-1:0] bin_addr,
  input  logic              bin_last,
  output logic              bin_ready,
  output logic              hist_wen_train_HCU,
  output logic [DATA_W-1:0] hist_wdata_train_HCU,
  output logic [ADDR_W-1:0] hist_addr_train_HCU,
  output logic              hist_ren_train_HCU,
  input  logic [DATA_W-1:0] hist_rdata_train_HCU,
  output logic              busy,
  output logic              done,
  output logic              sat_seen,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

  hcu_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_last;
  logic [DATA_W-1:0] inc_val;
  logic              inc_sat;

  hist_sat_inc #(
    .DATA_W (DATA_W)
  ) u_sat_inc (
    .val     (hist_rdata_train_HCU),
    .inc_val (inc_val),
    .sat     (inc_sat)
  );

  // Every output is registered: each branch loads the values the next state drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      clr_cnt              <= '0;
      cap_addr             <= '0;
      cap_last             <= 1'b0;
      bin_ready            <= 1'b0;
      hist_wen_train_HCU   <= 1'b0;
      hist_ren_train_HCU   <= 1'b0;
      hist_wdata_train_HCU <= '0;
      hist_addr_train_HCU  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      sat_seen             <= 1'b0;
      sample_cnt           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            sat_seen   <= 1'b0;
            sample_cnt <= '0;
            if (clear_en) begin
              state                <= S_CLEAR;
              clr_cnt              <= '0;
              hist_wen_train_HCU   <= 1'b1;
              hist_wdata_train_HCU <= '0;
              hist_addr_train_HCU  <= '0;
            end else begin
              state     <= S_FETCH;
              bin_ready <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (clr_cnt == LAST_BIN) begin
            state               <= S_FETCH;
            clr_cnt             <= '0;
            hist_wen_train_HCU  <= 1'b0;
            hist_addr_train_HCU <= '0;
            bin_ready           <= 1'b1;
          end else begin
            clr_cnt             <= clr_cnt + 1'b1;
            hist_addr_train_HCU <= clr_cnt + 1'b1;
          end
        end

        S_FETCH: begin
          if (bin_valid) begin
            state               <= S_RD;
            cap_addr            <= bin_addr;
            cap_last            <= bin_last;
            sample_cnt          <= sample_cnt + 1'b1;
            bin_ready           <= 1'b0;
            hist_ren_train_HCU  <= 1'b1;
            hist_addr_train_HCU <= bin_addr;
          end
        end

        S_RD: begin
          state               <= S_CAP;
          hist_ren_train_HCU  <= 1'b0;
          hist_addr_train_HCU <= '0;
        end

        // Read data lands this cycle; the write of this sample retires before the
        // next read, so back-to-back hits on one bin need no forwarding.
        S_CAP: begin
          state                <= S_WR;
          hist_wen_train_HCU   <= 1'b1;
          hist_addr_train_HCU  <= cap_addr;
          hist_wdata_train_HCU <= inc_val;
          if (inc_sat) sat_seen <= 1'b1;
        end

        S_WR: begin
          hist_wen_train_HCU   <= 1'b0;
          hist_wdata_train_HCU <= '0;
          hist_addr_train_HCU  <= '0;
          if (cap_last) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= S_FETCH;
            bin_ready <= 1'b1;
          end
        end

        S_FIN: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
